// File: rtl/act_func_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// definitions
// Shared types and constants for the activation-function scheduler:
//   Q_INT / Q_FRAC  : fixed-point format of samples, results and LUT words
//   ACT_MASK_SIZE   : width of the per-sample function select
//   fx_t            : signed fixed-point sample type
//   sched_state_t   : scheduler FSM states
// -----------------------------------------------------------------------------
package definitions;

  localparam int Q_INT         = 8;
  localparam int Q_FRAC        = 8;
  localparam int FX_W          = Q_INT + Q_FRAC;
  localparam int ACT_MASK_SIZE = 4;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    CONFIG = 2'd2
  } sched_state_t;

endpackage : definitions

// File: rtl/act_func_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping modulo N, and reports the pointer value that
// should follow that grant.
//   i_req      : request vector
//   i_ptr      : current round-robin pointer
//   o_grant    : one-hot grant (all zero when nothing is requested)
//   o_any      : a grant was issued
//   o_idx      : index of the granted requester (0 when none)
//   o_next_ptr : (granted index + 1) mod N, or i_ptr when nothing granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                          i_req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  i_ptr,
  output logic [N-1:0]                          o_grant,
  output logic                                  o_any,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  o_idx,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  o_next_ptr
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer upward; the first hit wins and later hits are ignored.
  always_comb begin
    o_grant    = '0;
    o_any      = 1'b0;
    o_idx      = '0;
    o_next_ptr = i_ptr;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_any          = 1'b1;
        o_idx          = w_idx;
        o_next_ptr     = PTR_W'((int'(w_idx) + 1) % N);
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/act_func_scheduler.sv
// -----------------------------------------------------------------------------
// act_func_scheduler
// Shares one activation unit among N_REQ requesters. Samples are granted
// round-robin, tagged with the requester id, and the unit's result is routed
// back to that requester ACT_LATENCY+2 cycles after the grant. A coefficient
// LUT reload first stops issue, waits for in-flight samples to leave the unit,
// then streams the words onto the unit's LUT write port.
//
// Ports
//   clk, reset                : clock, synchronous active-low reset
//   req_valid/ready           : per-requester handshake, one-hot combinational grant
//   req_x/mask/bypass         : per-requester sample, function select, pass-through
//   resp_valid/resp_fx        : one-hot single-cycle result strobe, shared result
//   cfg_valid/last/ready      : LUT reload word handshake and end marker
//   cfg_addr/cfg_data         : LUT reload word
//   act_x/mask/bypass         : registered sample drive to the activation unit
//   act_write_enable/addr/data: registered LUT write port of the activation unit
//   act_fx                    : activation unit result
// -----------------------------------------------------------------------------
module act_func_scheduler
  import definitions::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACT_LATENCY = 2,
  parameter int LUT_ADDR_W  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  output logic [N_REQ-1:0]                     req_ready,
  input  fx_t  [N_REQ-1:0]                     req_x,
  input  logic [N_REQ-1:0][ACT_MASK_SIZE-1:0]  req_mask,
  input  logic [N_REQ-1:0]                     req_bypass,
  output logic [N_REQ-1:0]                     resp_valid,
  output fx_t                                  resp_fx,
  input  logic                                 cfg_valid,
  input  logic                                 cfg_last,
  output logic                                 cfg_ready,
  input  logic [LUT_ADDR_W-1:0]                cfg_addr,
  input  fx_t                                  cfg_data,
  output fx_t                                  act_x,
  output logic [ACT_MASK_SIZE-1:0]             act_mask,
  output logic                                 act_bypass,
  output logic                                 act_write_enable,
  output logic [LUT_ADDR_W-1:0]                act_addr,
  output fx_t                                  act_data,
  input  fx_t                                  act_fx
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STAGES = 1 + ACT_LATENCY;

  // FSM
  sched_state_t r_state;
  sched_state_t w_next_state;
  logic         w_grant_en;
  logic         w_cfg_ready;
  logic         w_cfg_accept;
  logic         w_pipe_empty;

  // Arbitration
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_next_ptr;
  logic [ID_W-1:0]  w_grant_idx;
  logic [N_REQ-1:0] w_grant;
  logic             w_grant_any;
  logic [N_REQ-1:0] w_req_gated;

  // Tag pipeline, aligned with the sample travelling through the unit
  logic [STAGES-1:0]           r_tag_v;
  logic [STAGES-1:0][ID_W-1:0] r_tag_id;

  // Output / unit drive registers
  logic [N_REQ-1:0]          r_resp_valid;
  logic [N_REQ-1:0]          w_resp_onehot;
  fx_t                       r_resp_fx;
  fx_t                       r_act_x;
  logic [ACT_MASK_SIZE-1:0]  r_act_mask;
  logic                      r_act_bypass;
  logic                      r_act_we;
  logic [LUT_ADDR_W-1:0]     r_act_addr;
  fx_t                       r_act_data;

  assign w_req_gated = req_valid & {N_REQ{w_grant_en}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .i_req      (w_req_gated),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_any      (w_grant_any),
    .o_idx      (w_grant_idx),
    .o_next_ptr (w_next_ptr)
  );

  // Only the tags gate the drain: the last result occupies the output register
  // for the single cycle after its tag leaves, so CONFIG starts exactly when
  // that register has emptied.
  assign w_pipe_empty = ~|r_tag_v;
  assign w_cfg_accept = cfg_valid & w_cfg_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (cfg_valid) w_next_state = DRAIN;
        else           w_next_state = RUN;
      end
      DRAIN: begin
        if (w_pipe_empty) w_next_state = CONFIG;
        else              w_next_state = DRAIN;
      end
      CONFIG: begin
        if (cfg_valid && cfg_last) w_next_state = RUN;
        else                       w_next_state = CONFIG;
      end
      default: w_next_state = RUN;
    endcase
  end

  // FSM outputs: a pending reload wins over any same-cycle request
  always_comb begin
    w_grant_en  = 1'b0;
    w_cfg_ready = 1'b0;
    case (r_state)
      RUN: begin
        if (reset && !cfg_valid) w_grant_en = 1'b1;
        else                     w_grant_en = 1'b0;
      end
      DRAIN: begin
        w_grant_en  = 1'b0;
        w_cfg_ready = 1'b0;
      end
      CONFIG: begin
        w_cfg_ready = 1'b1;
      end
      default: begin
        w_grant_en  = 1'b0;
        w_cfg_ready = 1'b0;
      end
    endcase
  end

  // Round-robin pointer advances past each granted requester
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= w_next_ptr;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Tag shift register; stage 0 lines up with act_x
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s < STAGES; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Decode the final-stage tag into the requester strobe
  always_comb begin
    w_resp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_tag_v[STAGES-1] && (r_tag_id[STAGES-1] == ID_W'(i))) w_resp_onehot[i] = 1'b1;
      else                                                       w_resp_onehot[i] = 1'b0;
    end
  end

  // Output register: capture the unit result when its tag reaches the end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_valid <= '0;
      r_resp_fx    <= '0;
    end else begin
      r_resp_valid <= w_resp_onehot;
      if (r_tag_v[STAGES-1]) begin
        r_resp_fx <= act_fx;
      end else begin
        r_resp_fx <= r_resp_fx;
      end
    end
  end

  // Sample drive to the unit loads only on a grant and otherwise holds
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act_x      <= '0;
      r_act_mask   <= '0;
      r_act_bypass <= 1'b0;
    end else if (w_grant_any) begin
      r_act_x      <= req_x[w_grant_idx];
      r_act_mask   <= req_mask[w_grant_idx];
      r_act_bypass <= req_bypass[w_grant_idx];
    end else begin
      r_act_x      <= r_act_x;
      r_act_mask   <= r_act_mask;
      r_act_bypass <= r_act_bypass;
    end
  end

  // LUT write port: one registered write per accepted reload word
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act_we   <= 1'b0;
      r_act_addr <= '0;
      r_act_data <= '0;
    end else begin
      r_act_we <= w_cfg_accept;
      if (w_cfg_accept) begin
        r_act_addr <= cfg_addr;
        r_act_data <= cfg_data;
      end else begin
        r_act_addr <= r_act_addr;
        r_act_data <= r_act_data;
      end
    end
  end

  assign req_ready        = w_grant;
  assign cfg_ready        = w_cfg_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_fx          = r_resp_fx;
  assign act_x            = r_act_x;
  assign act_mask         = r_act_mask;
  assign act_bypass       = r_act_bypass;
  assign act_write_enable = r_act_we;
  assign act_addr         = r_act_addr;
  assign act_data         = r_act_data;

endmodule : act_func_scheduler

// File: doc/act_func_scheduler.md
# act_func_scheduler

Shares one `ActivationFunction` instance among `N_REQ` requesters (neuron-row accumulators) with round-robin arbitration, tags each issued sample so its result returns to the issuing requester, and sequences coefficient-LUT reloads. A reload stalls issue and drains the unit before any write. Sits between the accumulator array and the activation unit in the accelerator datapath.

## Interface
- `N_REQ`, 4: number of requesters.
- `ACT_LATENCY`, 2: cycles from `act_x` to valid `act_fx` inside the activation unit.
- `LUT_ADDR_W`, 8: coefficient LUT address width.
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-low.
- `req_valid` in `N_REQ`: per-requester sample valid.
- `req_ready` out `N_REQ`: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_x` in `N_REQ`×`Q_INT+Q_FRAC`: signed Q-format sample per requester.
- `req_mask` in `N_REQ`×`ACT_MASK_SIZE`: function select per requester.
- `req_bypass` in `N_REQ`: pass x through unchanged.
- `resp_valid` out `N_REQ`: one-hot, single-cycle result strobe; no backpressure.
- `resp_fx` out `Q_INT+Q_FRAC`: result, shared by all requesters.
- `cfg_valid`, `cfg_last` in 1: LUT reload word valid; last word.
- `cfg_ready` out 1: reload word accepted.
- `cfg_addr` in `LUT_ADDR_W`, `cfg_data` in `Q_INT+Q_FRAC`: LUT word.
- `act_x`, `act_mask`, `act_bypass` out: registered drive to the unit.
- `act_write_enable` out 1, `act_addr` out `LUT_ADDR_W`, `act_data` out `Q_INT+Q_FRAC`: registered LUT write port.
- `act_fx` in `Q_INT+Q_FRAC`: unit output.

## Operation
- States: RUN, DRAIN, CONFIG. Reset state is RUN.
- RUN
  - If `cfg_valid` = 0: grant the first `req_valid` at or after `rr_ptr` (wrapping modulo `N_REQ`). After a grant to index g, `rr_ptr` ← (g+1) mod `N_REQ`. With no grant, `rr_ptr` holds.
  - If `cfg_valid` = 1: `req_ready` = 0 and the next state is DRAIN. Config wins a simultaneous request.
- DRAIN: no grants, `cfg_ready` = 0. Move to CONFIG in the first cycle the tag pipeline and the output register hold no valid entries. If nothing is in flight, DRAIN lasts exactly one cycle.
- CONFIG
  - `cfg_ready` = 1.
  - Each accepted word is registered to `act_write_enable`=1, `act_addr`, `act_data` on the next cycle. Otherwise `act_write_enable` = 0.
  - The accepted word with `cfg_last` returns to RUN. Grants may resume on the cycle after that word is accepted.
  - `cfg_valid` low in CONFIG: wait; no timeout.
- Tag pipeline: `1+ACT_LATENCY` stages of {valid, id}, advanced every cycle.
  - On the final stage, the output register loads `resp_fx` ← `act_fx` and sets `resp_valid[id]` for one cycle.
- `act_x`, `act_mask`, `act_bypass` load only on a grant; otherwise they hold.
- Reset values: `req_ready`, `resp_valid`, `cfg_ready`, `act_write_enable` = 0. `resp_fx`, `act_x`, `act_mask`, `act_bypass`, `act_addr`, `act_data` = 0. `rr_ptr` = 0. All tags invalid.
- Reset mid-operation discards all in-flight results and aborts any reload. No `resp_valid` follows.

## Timing
- Grant is combinational from `req_valid` and state; at most one grant per cycle. Sustained throughput is 1 sample/cycle.
- Request accepted at cycle t:
  - `act_x` is valid at t+1.
  - `act_fx` is sampled at t+1+`ACT_LATENCY`.
  - `resp_valid`/`resp_fx` are asserted at t+2+`ACT_LATENCY` (4 with default `ACT_LATENCY`).
- Responses return in grant order.
- `cfg_valid` rising at cycle c with the last grant at c−1: DRAIN until that response issues at c+3. CONFIG begins at c+4.
- Config word accepted at cycle k appears on `act_write_enable` at k+1.

## Structure
- `definitions` package: `Q_INT`, `Q_FRAC`, `ACT_MASK_SIZE`, the fixed-point typedef, and a `sched_state_t` enum {RUN, DRAIN, CONFIG}.
- One sub-module, `rr_arbiter` (parameter `N`): one-hot grant from request vector and pointer, plus pointer update.
- The tag pipeline and FSM stay in `act_func_scheduler`.

## Test plan
- Single requester 0: `req_x`=−32768, `mask`=1 at t → `resp_valid`=0001 at t+4 with `resp_fx` equal to the model output.
- All four requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
- Requests {1,3} valid with `rr_ptr`=2 → grant 3, then 1; requester 0 is never granted.
- `cfg_valid` raised while 3 samples are in flight, same cycle as `req_valid` → no grant; 3 responses complete; `cfg_ready` rises after the last; 16 words written with `act_addr` 0..15; grants resume after `cfg_last`.
- `reset`=0 for one cycle with 2 samples in flight → all outputs 0 next cycle; no `resp_valid` ever appears for those samples; `rr_ptr`=0.
- `req_bypass`=1, `req_x`=0x1234 → `resp_fx`=0x1234 at latency 4.
